mem_load_align: RTL and testbench

Load-side counterpart of the data memory's byte-lane store path. Takes the raw 32-bit word returned by the data memory at the MEM stage, plus the load opcode and the low address bits. Extracts, sign/zero-extends or merges (LWL/LWR) the addressed bytes through a two-stage registered pipeline. Delivers the write-back value, destination register and address-error flag to the WB stage. Big-endian: byte offset 0 is bits [31:24].

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/load_lane_merge.sv | 57 +++++
 rtl/mem_load_align.sv | 109 ++++++++++
 tb/tb_mem_load_align.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS memory-path definitions: load/store opcodes, load kinds and opcode decode.
// The store-side byte-lane path imports the same constants.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  typedef enum logic [2:0] {
    LK_NONE,
    LK_B,
    LK_BU,
    LK_H,
    LK_HU,
    LK_W,
    LK_WL,
    LK_WR
  } load_kind_e;

  function automatic load_kind_e decode_load_kind(input logic [5:0] op);
    case (op)
      OP_LB:   return LK_B;
      OP_LBU:  return LK_BU;
      OP_LH:   return LK_H;
      OP_LHU:  return LK_HU;
      OP_LW:   return LK_W;
      OP_LWL:  return LK_WL;
      OP_LWR:  return LK_WR;
      default: return LK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/load_lane_merge.sv
// Combinational load lane datapath: big-endian byte/half extraction with sign or zero
// extension, LWL/LWR merge with the forwarded rt value, and misalignment detection.
module load_lane_merge
  import mips_pkg::*;
(
  input  load_kind_e         kind,
  input  logic [1:0]         addr_lo,
  input  logic [DATA_W-1:0]  mem_q,
  input  logic [DATA_W-1:0]  rt_old,
  output logic [DATA_W-1:0]  data,
  output logic               adel
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_s = mem_q[31:24];
      2'd1:    byte_s = mem_q[23:16];
      2'd2:    byte_s = mem_q[15:8];
      default: byte_s = mem_q[7:0];
    endcase
    half_s = addr_lo[1] ? mem_q[15:0] : mem_q[31:16];
  end

  // Misaligned loads report adel and deliver zero rather than a partial value.
  always_comb begin
    data = '0;
    adel = 1'b0;
    case (kind)
      LK_B:  data = 32'(byte_s);
      LK_BU: data = {24'd0, byte_s};
      LK_H:  if (addr_lo[0]) adel = 1'b1; else data = 32'(half_s);
      LK_HU: if (addr_lo[0]) adel = 1'b1; else data = {16'd0, half_s};
      LK_W:  if (addr_lo != 2'd0) adel = 1'b1; else data = mem_q;
      LK_WL: begin
        case (addr_lo)
          2'd0:    data = mem_q;
          2'd1:    data = {mem_q[23:0], rt_old[7:0]};
          2'd2:    data = {mem_q[15:0], rt_old[15:0]};
          default: data = {mem_q[7:0],  rt_old[23:0]};
        endcase
      end
      LK_WR: begin
        case (addr_lo)
          2'd0:    data = {rt_old[31:8],  mem_q[31:24]};
          2'd1:    data = {rt_old[31:16], mem_q[31:16]};
          2'd2:    data = {rt_old[31:24], mem_q[31:8]};
          default: data = mem_q;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_load_align.sv
// MEM->WB load alignment pipeline: S1 captures the raw memory word and load context,
// S2 registers the aligned/extended/merged write-back value with its write enable.
module mem_load_align
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [5:0]        opcode,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] mem_q,
  input  logic [DATA_W-1:0] rt_old,
  input  logic [REG_W-1:0]  dst_reg,
  output logic              out_valid,
  output logic              out_we,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_W-1:0]  out_dst,
  output logic              out_adel
);

  logic              vld_p1;
  logic [5:0]        op_p1;
  logic [1:0]        addr_p1;
  logic [DATA_W-1:0] mem_p1;
  logic [DATA_W-1:0] rt_p1;
  logic [REG_W-1:0]  dst_p1;

  logic              vld_p2;
  logic              we_p2;
  logic [DATA_W-1:0] data_p2;
  logic [REG_W-1:0]  dst_p2;
  logic              adel_p2;

  load_kind_e        kind_p1;
  logic [DATA_W-1:0] lane_data;
  logic              lane_adel;
  logic              load_ok;

  // S1: plain capture of the MEM-stage load context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      op_p1   <= '0;
      addr_p1 <= '0;
      mem_p1  <= '0;
      rt_p1   <= '0;
      dst_p1  <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      op_p1   <= '0;
      addr_p1 <= '0;
      mem_p1  <= '0;
      rt_p1   <= '0;
      dst_p1  <= '0;
    end else if (!stall) begin
      vld_p1  <= in_valid;
      op_p1   <= opcode;
      addr_p1 <= addr_lo;
      mem_p1  <= mem_q;
      rt_p1   <= rt_old;
      dst_p1  <= dst_reg;
    end
  end

  // S2: decode, lane select/merge, write-enable qualification
  assign kind_p1 = decode_load_kind(op_p1);

  load_lane_merge u_lane_merge (
    .kind    (kind_p1),
    .addr_lo (addr_p1),
    .mem_q   (mem_p1),
    .rt_old  (rt_p1),
    .data    (lane_data),
    .adel    (lane_adel)
  );

  assign load_ok = (kind_p1 != LK_NONE) && !lane_adel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      we_p2   <= 1'b0;
      data_p2 <= '0;
      dst_p2  <= '0;
      adel_p2 <= 1'b0;
    end else if (flush) begin
      vld_p2  <= 1'b0;
      we_p2   <= 1'b0;
      data_p2 <= '0;
      dst_p2  <= '0;
      adel_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p2  <= vld_p1;
      we_p2   <= vld_p1 && load_ok && (dst_p1 != '0);
      data_p2 <= vld_p1 ? lane_data : '0;
      dst_p2  <= dst_p1;
      adel_p2 <= vld_p1 && lane_adel;
    end
  end

  assign out_valid = vld_p2;
  assign out_we    = we_p2;
  assign out_data  = data_p2;
  assign out_dst   = dst_p2;
  assign out_adel  = adel_p2;

endmodule

// File: tb/tb_mem_load_align.sv
// Directed bench for mem_load_align: arithmetic reference model + in-order scoreboard,
// with literal expectations from the load-alignment rules.
module tb_mem_load_align;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  opcode = '0;
  logic [1:0]  addr_lo = '0;
  logic [31:0] mem_q = '0;
  logic [31:0] rt_old = '0;
  logic [4:0]  dst_reg = '0;
  logic        out_valid;
  logic        out_we;
  logic [31:0] out_data;
  logic [4:0]  out_dst;
  logic        out_adel;

  mem_load_align dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .opcode(opcode), .addr_lo(addr_lo), .mem_q(mem_q), .rt_old(rt_old), .dst_reg(dst_reg),
    .out_valid(out_valid), .out_we(out_we), .out_data(out_data), .out_dst(out_dst),
    .out_adel(out_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dst;
    logic        we;
    logic        adel;
    int          c;
    int          s;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   st = 0;
  bit   last_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Reference: byte/half picked by shifting the word, LWL/LWR as shifted word OR masked rt.
  function automatic exp_t model(input logic [5:0] op, input logic [1:0] off,
                                 input logic [31:0] mem, input logic [31:0] rt,
                                 input logic [4:0] dst);
    exp_t   e;
    longint m, r;
    int     b, h, k;
    e.data = '0; e.dst = dst; e.we = 1'b0; e.adel = 1'b0; e.c = 0; e.s = 0;
    k = int'(off);
    m = longint'(mem);
    r = longint'(rt);
    case (op)
      OP_LB, OP_LBU: begin
        b = int'((m >> (8 * (3 - k))) & 255);
        if (op == OP_LB && b > 127) b -= 256;
        e.data = 32'(b);
        e.we = 1'b1;
      end
      OP_LH, OP_LHU: begin
        if (k % 2 != 0) e.adel = 1'b1;
        else begin
          h = int'((m >> (16 * (1 - k / 2))) & 65535);
          if (op == OP_LH && h > 32767) h -= 65536;
          e.data = 32'(h);
          e.we = 1'b1;
        end
      end
      OP_LW: begin
        if (k != 0) e.adel = 1'b1;
        else begin e.data = mem; e.we = 1'b1; end
      end
      OP_LWL: begin
        e.data = 32'((m << (8 * k)) | (r & ((longint'(1) << (8 * k)) - 1)));
        e.we = 1'b1;
      end
      OP_LWR: begin
        e.data = 32'((m >> (8 * (3 - k))) | (r & ~((longint'(1) << (8 * (k + 1))) - 1)));
        e.we = 1'b1;
      end
      default: ;
    endcase
    if (dst == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  function automatic int age(input exp_t e);
    return (cyc - e.c) - (st - e.s);
  endfunction

  // Scoreboard: check outputs each negedge, then log what the next posedge will do.
  logic [31:0] pv_data;
  logic [4:0]  pv_dst;
  logic        pv_valid, pv_we, pv_adel;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_we",    32'(out_we),    32'd0);
        chk("rst_data",  out_data,       32'd0);
        chk("rst_dst",   32'(out_dst),   32'd0);
        chk("rst_adel",  32'(out_adel),  32'd0);
      end else if (last_stall) begin
        chk("hold_valid", 32'(out_valid), 32'(pv_valid));
        chk("hold_we",    32'(out_we),    32'(pv_we));
        chk("hold_data",  out_data,       pv_data);
        chk("hold_dst",   32'(out_dst),   32'(pv_dst));
        chk("hold_adel",  32'(out_adel),  32'(pv_adel));
      end else if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", 32'(out_valid), 32'd0);
        else begin
          e = q.pop_front();
          chk("latency", 32'(age(e)), 32'd2);
          chk("data",    out_data,      e.data);
          chk("we",      32'(out_we),   32'(e.we));
          chk("dst",     32'(out_dst),  32'(e.dst));
          chk("adel",    32'(out_adel), 32'(e.adel));
        end
      end else if (q.size() > 0 && age(q[0]) >= 2) begin
        chk("missing_valid", 32'(out_valid), 32'd1);
        void'(q.pop_front());
      end
      chk("we_without_valid", 32'(out_we & ~out_valid), 32'd0);
      pv_valid = out_valid; pv_we = out_we; pv_data = out_data;
      pv_dst = out_dst; pv_adel = out_adel;
      last_stall = 1'b0;
      if (!rst_n || flush) q.delete();
      else if (stall) begin st++; last_stall = 1'b1; end
      else if (in_valid) begin
        e = model(opcode, addr_lo, mem_q, rt_old, dst_reg);
        e.c = cyc;
        e.s = st;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input bit v, input logic [5:0] op, input logic [1:0] off,
                       input logic [31:0] m, input logic [31:0] r, input logic [4:0] d,
                       input bit stl, input bit fl);
    in_valid = v; opcode = op; addr_lo = off; mem_q = m; rt_old = r; dst_reg = d;
    stall = stl; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t pe;
    // Literal pins of the reference model
    pe = model(OP_LB, 2'd0, 32'h8081_7F02, 32'd0, 5'd1);  chk("pin_lb0",  pe.data, 32'hFFFF_FF80);
    pe = model(OP_LB, 2'd2, 32'h8081_7F02, 32'd0, 5'd1);  chk("pin_lb2",  pe.data, 32'h0000_007F);
    pe = model(OP_LBU, 2'd1, 32'h8081_7F02, 32'd0, 5'd1); chk("pin_lbu1", pe.data, 32'h0000_0081);
    pe = model(OP_LWL, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 5'd1); chk("pin_lwl1", pe.data, 32'h2233_44DD);
    pe = model(OP_LWR, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 5'd1); chk("pin_lwr1", pe.data, 32'hAABB_1122);
    pe = model(OP_LWR, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 5'd1); chk("pin_lwr3", pe.data, 32'h1122_3344);
    pe = model(OP_LH, 2'd2, 32'h0000_8001, 32'd0, 5'd1);  chk("pin_lh2",  pe.data, 32'hFFFF_8001);
    pe = model(OP_LHU, 2'd1, 32'h0000_8001, 32'd0, 5'd1); chk("pin_lhu1_adel", 32'(pe.adel), 32'd1);
    pe = model(OP_LW, 2'd0, 32'h1234_5678, 32'd0, 5'd0);  chk("pin_lw_r0_we", 32'(pe.we), 32'd0);

    idle(); idle();
    chk("reset_state_valid", 32'(out_valid), 32'd0);
    chk("reset_state_data",  out_data,       32'd0);
    rst_n = 1'b1;
    idle();

    // LB / LBU on every offset, back to back
    for (int k = 0; k < 4; k++) drive(1'b1, OP_LB,  2'(k), 32'h8081_7F02, 32'd0, 5'd3, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, OP_LBU, 2'(k), 32'h8081_7F02, 32'd0, 5'd4, 1'b0, 1'b0);
    idle(); idle();

    // LWL/LWR merges; first one checked literally two edges after issue
    drive(1'b1, OP_LWL, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 5'd5, 1'b0, 1'b0);
    drive(1'b1, OP_LWR, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 5'd6, 1'b0, 1'b0);
    chk("lit_lwl1", out_data, 32'h2233_44DD);
    drive(1'b1, OP_LWL, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 5'd7, 1'b0, 1'b0);
    chk("lit_lwr1", out_data, 32'hAABB_1122);
    drive(1'b1, OP_LWR, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 5'd8, 1'b0, 1'b0);
    drive(1'b1, OP_LWL, 2'd2, 32'h1122_3344, 32'hAABB_CCDD, 5'd9, 1'b0, 1'b0);
    drive(1'b1, OP_LWR, 2'd2, 32'h1122_3344, 32'hAABB_CCDD, 5'd9, 1'b0, 1'b0);
    drive(1'b1, OP_LWL, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 5'd9, 1'b0, 1'b0);
    drive(1'b1, OP_LWR, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 5'd9, 1'b0, 1'b0);

    // Halves, misalignment, non-load
    drive(1'b1, OP_LH,  2'd2, 32'h0000_8001, 32'd0, 5'd10, 1'b0, 1'b0);
    drive(1'b1, OP_LHU, 2'd1, 32'h0000_8001, 32'd0, 5'd11, 1'b0, 1'b0);
    chk("lit_lh2", out_data, 32'hFFFF_8001);
    drive(1'b1, OP_LW,  2'd2, 32'hDEAD_BEEF, 32'd0, 5'd12, 1'b0, 1'b0);
    chk("lit_lhu1_adel", 32'(out_adel), 32'd1);
    chk("lit_lhu1_we",   32'(out_we),   32'd0);
    drive(1'b1, OP_LHU, 2'd0, 32'hFEDC_0001, 32'd0, 5'd13, 1'b0, 1'b0);
    chk("lit_lw2_adel", 32'(out_adel), 32'd1);
    drive(1'b1, 6'b000000, 2'd0, 32'hFFFF_FFFF, 32'd0, 5'd14, 1'b0, 1'b0);
    drive(1'b1, OP_LW,  2'd0, 32'hCAFE_F00D, 32'd0, 5'd15, 1'b0, 1'b0);
    idle();

    // Stall for three cycles with loads in both stages
    drive(1'b1, OP_LW, 2'd0, 32'hA000_000A, 32'd0, 5'd16, 1'b0, 1'b0);
    drive(1'b1, OP_LW, 2'd0, 32'hB000_000B, 32'd0, 5'd17, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_LW, 2'd0, 32'hEEEE_EEEE, 32'd0, 5'd31, 1'b1, 1'b0);
      chk("lit_stall_hold", out_data, 32'hA000_000A);
    end
    drive(1'b1, OP_LW, 2'd0, 32'hC000_000C, 32'd0, 5'd18, 1'b0, 1'b0);
    chk("lit_stall_next", out_data, 32'hB000_000B);
    drive(1'b1, OP_LW, 2'd0, 32'hD000_000D, 32'd0, 5'd19, 1'b0, 1'b0);
    idle(); idle();

    // Flush with loads in both stages (stall also high: flush wins)
    drive(1'b1, OP_LW, 2'd0, 32'h1111_1111, 32'd0, 5'd20, 1'b0, 1'b0);
    drive(1'b1, OP_LW, 2'd0, 32'h2222_2222, 32'd0, 5'd21, 1'b0, 1'b0);
    drive(1'b1, OP_LW, 2'd0, 32'h3333_3333, 32'd0, 5'd22, 1'b1, 1'b1);
    chk("lit_flush_valid0", 32'(out_valid), 32'd0);
    chk("lit_flush_we0",    32'(out_we),    32'd0);
    drive(1'b1, OP_LB, 2'd3, 32'h0000_00F0, 32'd0, 5'd23, 1'b0, 1'b0);
    chk("lit_flush_valid1", 32'(out_valid), 32'd0);
    idle();
    chk("lit_post_flush_valid", 32'(out_valid), 32'd1);
    chk("lit_post_flush_data",  out_data,       32'hFFFF_FFF0);
    idle();

    // Asynchronous reset with loads in flight
    drive(1'b1, OP_LW, 2'd0, 32'h4444_4444, 32'd0, 5'd24, 1'b0, 1'b0);
    drive(1'b1, OP_LW, 2'd0, 32'h5555_5555, 32'd0, 5'd25, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("lit_async_rst_valid", 32'(out_valid), 32'd0);
    chk("lit_async_rst_data",  out_data,       32'd0);
    idle();
    rst_n = 1'b1;
    drive(1'b1, OP_LW, 2'd0, 32'h7777_7777, 32'd0, 5'd0, 1'b0, 1'b0);
    idle();
    chk("lit_r0_valid", 32'(out_valid), 32'd1);
    chk("lit_r0_we",    32'(out_we),    32'd0);
    idle(); idle(); idle();
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
